// File: rtl/uart_tx_dev.sv
// Bus-attached UART transmitter: CPU writes bytes into a FIFO, sent as 8N1 frames on txd.
// Define UART_TX_PARITY_EN to add an even-parity bit, enabled at run time by CTRL[1].
module uart_tx_dev #(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          FIFO_AW     = 3,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state;
  logic [2:0]         bit_cnt;
  logic [15:0]        baud_cnt;
  logic [15:0]        frame_div;
  logic [7:0]         shift;
  logic [15:0]        div_reg;
  logic               irq_en;
  logic               ovf;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
`ifdef UART_TX_PARITY_EN
  logic               par_en;
  logic               par_frame;
  logic               par_bit;
`endif

  logic [1:0] sel;
  logic       wr_data, wr_status, wr_div, wr_ctrl;
  logic       empty, full, pop, push_ok, busy, baud_done;
  logic       unused_ok;

  assign sel       = Addr[1:0];
  assign wr_data   = WE && (sel == 2'd0);
  assign wr_status = WE && (sel == 2'd1);
  assign wr_div    = WE && (sel == 2'd2);
  assign wr_ctrl   = WE && (sel == 2'd3);
  assign unused_ok = ^{Addr[29:2], Din[31:16]};

  assign empty     = (count == '0);
  assign full      = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign pop       = (state == IDLE) && !empty;
  // A full FIFO still takes the byte when the transmitter frees a slot in the same cycle.
  assign push_ok   = wr_data && (!full || pop);
  assign busy      = (state != IDLE) || !empty;
  assign baud_done = (baud_cnt == frame_div - 16'd1);

  // NOTE: the storage array has no reset; empty/count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= Din[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= DEFAULT_DIV;
      irq_en  <= 1'b0;
      ovf     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en  <= 1'b0;
`endif
    end else begin
      if (wr_div)  div_reg <= (Din[15:0] < 16'd2) ? 16'd2 : Din[15:0];
      if (wr_ctrl) begin
        irq_en <= Din[0];
`ifdef UART_TX_PARITY_EN
        par_en <= Din[1];
`endif
      end
      if (wr_status)                ovf <= 1'b0;
      else if (wr_data && !push_ok) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      frame_div <= DEFAULT_DIV;
      shift     <= '0;
      txd       <= 1'b1;
      IRQ       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_frame <= 1'b0;
      par_bit   <= 1'b0;
`endif
    end else begin
      IRQ <= irq_en && empty && (state == IDLE);
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            shift     <= mem[rd_ptr];
            frame_div <= div_reg;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            txd       <= 1'b0;
            state     <= START;
`ifdef UART_TX_PARITY_EN
            par_frame <= par_en;
            par_bit   <= ^mem[rd_ptr];
`endif
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            txd      <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd   <= par_frame ? par_bit : 1'b1;
              state <= par_frame ? PARITY : STOP;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            txd      <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (sel)
      2'd1: begin
        Dout[0]           = busy;
        Dout[1]           = full;
        Dout[2]           = empty;
        Dout[3]           = ovf;
        Dout[FIFO_AW+8:8] = count;
      end
      2'd2: Dout[15:0] = div_reg;
      2'd3: begin
        Dout[0] = irq_en;
`ifdef UART_TX_PARITY_EN
        Dout[1] = par_en;
`endif
      end
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed self-checking bench for uart_tx_dev: registers, framing, FIFO overflow, IRQ, reset.
// Stimulus and sampling both happen on the falling clock edge, away from the active edge.
module tb_uart_tx_dev;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] rd;
  logic [7:0]  rx_b;
  int          rx_start;
  int          rx_prev;

  uart_tx_dev dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ),
    .txd  (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Write is sampled by the next rising edge; returns on the falling edge after it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Din  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'd0, a};
    WE   = 1'b0;
    #1;
    d = Dout;
  endtask

  // Entered on the first cycle of the start bit; bits[i] is the i-th bit on the wire.
  task automatic check_bits(input string tag, input logic [10:0] bits, input int nbits,
                            input int div);
    logic [31:0] seen, want;
    for (int i = 0; i < nbits; i++) begin
      seen = '0;
      want = '0;
      for (int k = 0; k < div; k++) begin
        seen = {seen[30:0], txd};
        want = {want[30:0], bits[i]};
        if (!(i == nbits - 1 && k == div - 1)) @(negedge clk);
      end
      check($sformatf("%s bit%0d", tag, i), seen, want);
    end
  endtask

  // Waits for a start bit, samples each bit mid-period, returns on the last stop cycle.
  task automatic recv_byte(input int div, output logic [7:0] b, output int start_cyc);
    int t;
    t = 0;
    b = 'x;
    start_cyc = 0;
    while (txd !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (txd !== 1'b0) begin
      check("rx start timeout", {31'd0, txd}, 32'd0);
      return;
    end
    start_cyc = cyc;
    step(div / 2);
    check("rx start bit", {31'd0, txd}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(div);
      b[i] = txd;
    end
    step(div);
    check("rx stop bit", {31'd0, txd}, 32'd1);
    step(div - div / 2 - 1);
  endtask

  initial begin
    reset = 1'b1;
    Addr  = '0;
    WE    = 1'b0;
    Din   = '0;
    step(2);
    reset = 1'b0;

    // Reset state
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset irq", {31'd0, IRQ}, 32'd0);
    bus_read(2'd0, rd); check("reset data", rd, 32'h0);
    bus_read(2'd1, rd); check("reset status", rd, 32'h4);
    bus_read(2'd2, rd); check("reset div", rd, 32'd434);
    bus_read(2'd3, rd); check("reset ctrl", rd, 32'h0);

    // Single frame 0x55 at DIV=4: txd falls one edge after the write edge
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h55);
    check("txd before pop", {31'd0, txd}, 32'd1);
    step(1);
    check_bits("frame55", {1'b0, 1'b1, 8'h55, 1'b0}, 10, 4);
    bus_read(2'd1, rd); check("busy in stop", rd, 32'h5);
    step(1);
    bus_read(2'd1, rd); check("idle after frame", rd, 32'h4);

    // FIFO fill at DIV=2 with a concurrent receiver
    bus_write(2'd2, 32'd2);
    fork
      begin
        for (int f = 0; f < 9; f++) begin
          recv_byte(2, rx_b, rx_start);
          check($sformatf("rx byte%0d", f), {24'd0, rx_b}, f);
          if (f > 0) check($sformatf("rx gap%0d", f), rx_start - rx_prev, 32'd21);
          rx_prev = rx_start;
        end
      end
      begin
        for (int i = 0; i < 9; i++) bus_write(2'd0, i);
        bus_read(2'd1, rd); check("status full", rd, 32'h803);
        bus_write(2'd0, 32'hEE);
        bus_read(2'd1, rd); check("status ovf", rd, 32'h80B);
        bus_write(2'd1, 32'h0);
        bus_read(2'd1, rd); check("ovf cleared", rd, 32'h803);
      end
    join
    step(1);
    bus_read(2'd1, rd); check("drained status", rd, 32'h4);

    // IRQ timing
    bus_write(2'd3, 32'h1);
    step(1);
    check("irq on empty", {31'd0, IRQ}, 32'd1);
    bus_write(2'd0, 32'hA3);
    step(1);
    check("irq after push", {31'd0, IRQ}, 32'd0);
    check("txd start A3", {31'd0, txd}, 32'd0);
    step(20);
    check("irq at stop end", {31'd0, IRQ}, 32'd0);
    check("txd idle A3", {31'd0, txd}, 32'd1);
    step(1);
    check("irq returns", {31'd0, IRQ}, 32'd1);
    bus_write(2'd3, 32'h0);
    step(1);
    check("irq disabled", {31'd0, IRQ}, 32'd0);

    // Asynchronous reset during bit 3 of 0xFF, with another byte queued
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'hFF);
    bus_write(2'd0, 32'hAA);
    step(17);
    check("txd bit3 FF", {31'd0, txd}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("reset mid txd", {31'd0, txd}, 32'd1);
    bus_read(2'd1, rd); check("reset mid status", rd, 32'h4);
    bus_read(2'd2, rd); check("reset mid div", rd, 32'd434);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset during a start bit: txd must rise without a clock edge
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h00);
    step(1);
    check("start before reset", {31'd0, txd}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async reset txd", {31'd0, txd}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h3C);
    step(1);
    check_bits("frame3C", {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 4);
    step(1);
    bus_read(2'd1, rd); check("idle after 3C", rd, 32'h4);

    // DIV clamp and CTRL readback
    bus_write(2'd2, 32'd1);
    bus_read(2'd2, rd); check("div clamp 1", rd, 32'd2);
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, rd); check("div clamp 0", rd, 32'd2);
    bus_write(2'd2, 32'h0001_0003);
    bus_read(2'd2, rd); check("div 3", rd, 32'd3);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);
`ifdef UART_TX_PARITY_EN
    check("ctrl readback", rd, 32'h3);
    bus_write(2'd2, 32'd2);
    bus_write(2'd3, 32'h2);
    bus_write(2'd0, 32'h07);
    step(1);
    check_bits("frame07p", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 2);
    step(1);
    bus_read(2'd1, rd); check("idle after parity", rd, 32'h4);
`else
    check("ctrl readback", rd, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
